// File: rtl/cache_ctrl.sv
// cache_ctrl: CPU-side controller for a 2-way set-associative data cache.
// A CPU request becomes a cache lookup. A hit completes in the following cycle.
// A miss first writes a dirty victim line back to memory, then refills the line
// word by word, and finally re-issues the held request so that it hits.
module cache_ctrl #(
    parameter int unsigned ADDR_BITS       = 32,
    parameter int unsigned TAG_BITS        = 23,
    parameter int unsigned SET_INDEX_WIDTH = 5,
    parameter int unsigned LINE_WORDS      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic [31:0]          cache_dout,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned WORD_SEL_BITS = $clog2(LINE_WORDS);
    localparam int unsigned LINE_LSB      = WORD_SEL_BITS + 2;
    localparam int unsigned INDEX_MSB     = LINE_LSB + SET_INDEX_WIDTH - 1;
    localparam logic [WORD_SEL_BITS-1:0] LAST_WORD = WORD_SEL_BITS'(LINE_WORDS - 1);
    localparam logic [2:0] ACC_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_BACK = 2'd2,
        S_FILL = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [WORD_SEL_BITS-1:0]   word_cnt_q, word_cnt_d;
    logic                       bubble_q, bubble_d;
    logic [TAG_BITS-1:0]        victim_tag_q, victim_tag_d;
    logic [31:0]                rdata_q, rdata_d;

    logic                       req_c;
    logic                       hit_done_c;
    logic [SET_INDEX_WIDTH-1:0] index_c;
    logic [ADDR_BITS-1:0]       back_addr_c;
    logic [ADDR_BITS-1:0]       fill_addr_c;

    assign req_c       = en_r | en_w;
    assign hit_done_c  = (state_q == S_TAG) && cache_hit;
    assign index_c     = addr_rw[INDEX_MSB:LINE_LSB];
    assign back_addr_c = {victim_tag_q, index_c, word_cnt_q, 2'b00};
    assign fill_addr_c = {addr_rw[ADDR_BITS-1:LINE_LSB], word_cnt_q, 2'b00};

    // CPU-facing handshake: freeze until the lookup reports a hit; read data is
    // forwarded in the completing cycle and held afterwards.
    always_comb begin
        stall  = rst && req_c && !hit_done_c;
        data_r = (hit_done_c && en_r) ? cache_dout : rdata_q;
    end

    // State register and transfer bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            bubble_q     <= 1'b0;
            victim_tag_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            bubble_q     <= bubble_d;
            victim_tag_q <= victim_tag_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next state plus cache and memory strobes for the current phase.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        bubble_d      = 1'b0;
        victim_tag_d  = victim_tag_q;
        rdata_d       = rdata_q;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_store   = 1'b0;
        cache_u_b_h_w = 3'b000;
        cache_din     = 32'h0;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (rst && req_c) begin
                    cache_addr    = addr_rw;
                    cache_load    = en_r;
                    cache_edit    = en_w && !en_r;
                    cache_din     = data_w;
                    cache_u_b_h_w = u_b_h_w;
                    state_d       = S_TAG;
                end
            end

            S_TAG: begin
                if (cache_hit) begin
                    if (en_r) begin
                        rdata_d = cache_dout;
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_tag_d = cache_tag;
                    word_cnt_d   = '0;
                    if (cache_valid && cache_dirty) begin
                        // First write-back cycle only presents the victim address.
                        bubble_d = 1'b1;
                        state_d  = S_BACK;
                    end else begin
                        state_d  = S_FILL;
                    end
                end
            end

            S_BACK: begin
                // No strobe: the cache just reads out the victim word.
                cache_addr = back_addr_c;
                if (!bubble_q) begin
                    mem_cs_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = back_addr_c;
                    mem_data_o = cache_dout;
                    if (mem_ack_i) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = S_FILL;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                            bubble_d   = 1'b1;
                        end
                    end
                end
            end

            S_FILL: begin
                if (!bubble_q) begin
                    mem_cs_o   = 1'b1;
                    mem_addr_o = fill_addr_c;
                    if (mem_ack_i) begin
                        cache_store   = 1'b1;
                        cache_addr    = fill_addr_c;
                        cache_din     = mem_data_i;
                        cache_u_b_h_w = ACC_WORD;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                            bubble_d   = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench for cache_ctrl with a behavioural
// 2-way cache (registered outputs, LRU victim) and a memory with settable ack delay.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] addr_rw;
    logic        en_r;
    logic        en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load;
    logic        cache_edit;
    logic        cache_store;
    logic [2:0]  cache_u_b_h_w;
    logic [31:0] cache_din;
    logic [31:0] cache_dout;
    logic        cache_hit;
    logic        cache_valid;
    logic        cache_dirty;
    logic [22:0] cache_tag;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    cache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .addr_rw       (addr_rw),
        .en_r          (en_r),
        .en_w          (en_w),
        .u_b_h_w       (u_b_h_w),
        .data_w        (data_w),
        .data_r        (data_r),
        .stall         (stall),
        .cache_addr    (cache_addr),
        .cache_load    (cache_load),
        .cache_edit    (cache_edit),
        .cache_store   (cache_store),
        .cache_u_b_h_w (cache_u_b_h_w),
        .cache_din     (cache_din),
        .cache_dout    (cache_dout),
        .cache_hit     (cache_hit),
        .cache_valid   (cache_valid),
        .cache_dirty   (cache_dirty),
        .cache_tag     (cache_tag),
        .mem_cs_o      (mem_cs_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ack_dly = 0;

    logic [31:0] rd_q [$];
    logic [31:0] fill_q [$];
    logic [63:0] wb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] memory [logic [31:0]];
    int          wcnt;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h0000_0034) return 32'h80FF_0000;
        return 32'hA0 + 32'(a[3:2]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ack_i  <= 1'b0;
            mem_data_i <= 32'h0;
            wcnt       <= 0;
        end else begin
            mem_ack_i <= 1'b0;
            if (mem_cs_o && !mem_ack_i) begin
                if (wcnt >= ack_dly) begin
                    mem_ack_i <= 1'b1;
                    wcnt      <= 0;
                    if (mem_we_o) memory[mem_addr_o] = mem_data_o;
                    else mem_data_i <= memory.exists(mem_addr_o) ? memory[mem_addr_o] : mem_init(mem_addr_o);
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- cache model ----------------
    logic [22:0] c_tag   [2][32];
    logic        c_val   [2][32];
    logic        c_dirty [2][32];
    logic [31:0] c_data  [2][32][4];
    logic        c_lru   [32];

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f, input logic [1:0] bo);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {bo, 3'b000});
        h = 16'(w >> {bo[1], 4'b0000});
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [2:0] f, input logic [1:0] bo);
        logic [31:0] m;
        case (f[1:0])
            2'b00:   m = 32'h0000_00FF << {bo, 3'b000};
            2'b01:   m = 32'h0000_FFFF << {bo[1], 4'b0000};
            default: return d;
        endcase
        return (old & ~m) | ((d << {bo, 3'b000}) & m);
    endfunction

    int          cm_idx;
    int          cm_w;
    int          cm_way;
    logic        cm_h;
    logic [22:0] cm_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 32; s++) begin
                c_lru[s] = 1'b0;
                for (int wy = 0; wy < 2; wy++) begin
                    c_val[wy][s]   = 1'b0;
                    c_dirty[wy][s] = 1'b0;
                    c_tag[wy][s]   = '0;
                    for (int k = 0; k < 4; k++) c_data[wy][s][k] = 32'h0;
                end
            end
            cache_hit   <= 1'b0;
            cache_valid <= 1'b0;
            cache_dirty <= 1'b0;
            cache_tag   <= '0;
            cache_dout  <= 32'h0;
        end else begin
            cm_idx = int'(cache_addr[8:4]);
            cm_w   = int'(cache_addr[3:2]);
            cm_t   = cache_addr[31:9];
            cm_h   = 1'b0;
            cm_way = int'(c_lru[cm_idx]);
            for (int i = 0; i < 2; i++)
                if (c_val[i][cm_idx] && c_tag[i][cm_idx] == cm_t) begin
                    cm_h   = 1'b1;
                    cm_way = i;
                end
            if (cache_load || cache_edit) begin
                if (cm_h) begin
                    c_lru[cm_idx] = (cm_way == 0);
                    if (cache_edit) begin
                        c_data[cm_way][cm_idx][cm_w] = st_merge(c_data[cm_way][cm_idx][cm_w],
                                                                cache_din, cache_u_b_h_w, cache_addr[1:0]);
                        c_dirty[cm_way][cm_idx] = 1'b1;
                    end
                end
                cache_hit <= cm_h;
            end else if (cache_store) begin
                cm_way = int'(c_lru[cm_idx]);
                c_data[cm_way][cm_idx][cm_w] = cache_din;
                c_tag[cm_way][cm_idx]        = cm_t;
                c_val[cm_way][cm_idx]        = 1'b1;
                c_dirty[cm_way][cm_idx]      = 1'b0;
                cache_hit <= 1'b0;
            end else begin
                cache_hit <= 1'b0;
            end
            cache_valid <= c_val[cm_way][cm_idx];
            cache_dirty <= c_dirty[cm_way][cm_idx];
            cache_tag   <= c_tag[cm_way][cm_idx];
            cache_dout  <= (cache_load && cm_h) ? ld_ext(c_data[cm_way][cm_idx][cm_w], cache_u_b_h_w, cache_addr[1:0])
                                                : c_data[cm_way][cm_idx][cm_w];
        end
    end

    // ---------------- monitor ----------------
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_we   = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [63:0] ew;
        if (rst && en_r && !stall) begin
            if (rd_q.size() == 0) chk("rd_unexpected", data_r, 32'hxxxx_xxxx);
            else begin
                e = rd_q.pop_front();
                chk("data_r", data_r, e);
            end
        end
        if (rst && mem_cs_o && hold_prev) begin
            chk("mem_addr_hold", mem_addr_o, prev_addr);
            if (prev_we) chk("mem_data_hold", mem_data_o, prev_data);
        end
        if (rst && mem_cs_o && mem_ack_i) begin
            if (mem_we_o) begin
                if (wb_q.size() == 0) chk("wb_unexpected", mem_addr_o, 32'hxxxx_xxxx);
                else begin
                    ew = wb_q.pop_front();
                    chk("wb_addr", mem_addr_o, ew[63:32]);
                    chk("wb_data", mem_data_o, ew[31:0]);
                end
            end else begin
                if (fill_q.size() == 0) chk("fill_unexpected", mem_addr_o, 32'hxxxx_xxxx);
                else begin
                    e = fill_q.pop_front();
                    chk("fill_addr", mem_addr_o, e);
                end
            end
        end
        hold_prev = rst && mem_cs_o && !mem_ack_i;
        prev_addr = mem_addr_o;
        prev_data = mem_data_o;
        prev_we   = mem_we_o;
    end

    // ---------------- stimulus ----------------
    task automatic push_fill(input logic [31:0] base);
        for (int k = 0; k < 4; k++) fill_q.push_back(base + 32'(4 * k));
    endtask

    task automatic cpu_op(input logic rd, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] wd, input logic [31:0] exp,
                          output int stall_cyc, output int cs_cyc);
        logic done;
        done      = 1'b0;
        stall_cyc = 0;
        cs_cyc    = 0;
        if (rd) rd_q.push_back(exp);
        @(posedge clk);
        #1;
        addr_rw = a;
        u_b_h_w = f;
        data_w  = wd;
        en_r    = rd;
        en_w    = !rd;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (mem_cs_o) cs_cyc++;
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        chk("op_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    int sc;
    int cc;

    initial begin
        rst     = 1'b0;
        en_r    = 1'b1;
        en_w    = 1'b0;
        addr_rw = 32'h0000_0104;
        u_b_h_w = 3'b010;
        data_w  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data_r", data_r, 32'h0);
        chk("rst_strobes", {29'h0, cache_load, cache_edit, cache_store}, 32'h0);
        chk("rst_mem_cs", 32'(mem_cs_o), 32'd0);
        en_r = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // cold read: no write-back, line filled, re-issued load hits
        ack_dly = 0;
        push_fill(32'h0000_0100);
        cpu_op(1'b1, 32'h0000_0104, 3'b010, 32'h0, 32'h0000_00A1, sc, cc);

        // repeat read hits with a single stall cycle
        cpu_op(1'b1, 32'h0000_0104, 3'b010, 32'h0, 32'h0000_00A1, sc, cc);
        chk("hit_stall_cycles", 32'(sc), 32'd1);
        chk("hit_mem_cs_cycles", 32'(cc), 32'd0);

        // store hit stays in cache
        cpu_op(1'b0, 32'h0000_0108, 3'b010, 32'h1234_5678, 32'h0, sc, cc);
        chk("sw_stall_cycles", 32'(sc), 32'd1);
        chk("sw_mem_cs_cycles", 32'(cc), 32'd0);

        // second way of set 0x10 is still free
        push_fill(32'h0000_2100);
        cpu_op(1'b1, 32'h0000_2104, 3'b010, 32'h0, 32'h0000_00A1, sc, cc);

        // third line evicts the dirty 0x100 line
        wb_q.push_back({32'h0000_0100, 32'h0000_00A0});
        wb_q.push_back({32'h0000_0104, 32'h0000_00A1});
        wb_q.push_back({32'h0000_0108, 32'h1234_5678});
        wb_q.push_back({32'h0000_010C, 32'h0000_00A3});
        push_fill(32'h0000_4100);
        cpu_op(1'b1, 32'h0000_4104, 3'b010, 32'h0, 32'h0000_00A1, sc, cc);

        // signed and unsigned byte loads of the top byte of 0x80FF_0000
        push_fill(32'h0000_0030);
        cpu_op(1'b1, 32'h0000_0037, 3'b000, 32'h0, 32'hFFFF_FF80, sc, cc);
        cpu_op(1'b1, 32'h0000_0037, 3'b100, 32'h0, 32'h0000_0080, sc, cc);
        chk("lbu_stall_cycles", 32'(sc), 32'd1);

        // slow memory: write-back and fill with 5-cycle ack delay
        ack_dly = 5;
        push_fill(32'h0000_0050);
        cpu_op(1'b0, 32'h0000_0054, 3'b010, 32'hDEAD_BEEF, 32'h0, sc, cc);
        push_fill(32'h0000_0250);
        cpu_op(1'b1, 32'h0000_0254, 3'b010, 32'h0, 32'h0000_00A1, sc, cc);
        wb_q.push_back({32'h0000_0050, 32'h0000_00A0});
        wb_q.push_back({32'h0000_0054, 32'hDEAD_BEEF});
        wb_q.push_back({32'h0000_0058, 32'h0000_00A2});
        wb_q.push_back({32'h0000_005C, 32'h0000_00A3});
        push_fill(32'h0000_0450);
        cpu_op(1'b1, 32'h0000_0454, 3'b010, 32'h0, 32'h0000_00A5 - 32'h4, sc, cc);

        // reset during the second fill word
        fill_q.push_back(32'h0000_00C0);
        @(posedge clk);
        #1;
        addr_rw = 32'h0000_00C4;
        u_b_h_w = 3'b010;
        en_r    = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (mem_cs_o && mem_addr_o == 32'h0000_00C4) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("reach_fill_word1", 32'(seen), 32'd1);
        end
        rst = 1'b0;
        #1;
        chk("abort_state", 32'(dut.state_q), 32'd0);
        chk("abort_word_cnt", 32'(dut.word_cnt_q), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_mem_cs", 32'(mem_cs_o), 32'd0);
        @(posedge clk);
        #1;
        en_r = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
